// File: rtl/flopr.sv
// ============================================================================
// Module      : flopr
// Description : WIDTH-bit D register with asynchronous, active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flopr #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Per-bit RESET_VALUE maps each flop onto an async set or async clear cell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flopr.sv
// ============================================================================
// Module      : tb_flopr
// Description : Directed self-checking bench for flopr at widths 32, 108 and 8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flopr;

  logic         clk = 1'b0;
  logic         reset32, reset108, reset8;
  logic [31:0]  d32, q32;
  logic [107:0] d108, q108;
  logic [7:0]   d8, q8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flopr #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset32), .d(d32), .q(q32)
  );

  flopr #(.WIDTH(108), .RESET_VALUE(108'h0)) dut108 (
    .clk(clk), .reset(reset108), .d(d108), .q(q108)
  );

  flopr #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .clk(clk), .reset(reset8), .d(d8), .q(q8)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [107:0] vec [4];
    logic [107:0] prev;
    time          t_raise;

    // Reset all instances with garbage on d.
    reset32  = 1'b1;
    reset108 = 1'b1;
    reset8   = 1'b1;
    d32      = 32'hDEADBEEF;
    d108     = '1;
    d8       = 8'hFF;
    #1;
    chk("rst32_async", 128'(q32), 128'h0);
    chk("rst108_async", 128'(q108), 128'h0);
    chk("rst8_value", 128'(q8), 128'hA5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst32_edge_ignored", 128'(q32), 128'h0);
      chk("rst8_edge_ignored", 128'(q8), 128'hA5);
    end

    // Release reset: q holds reset value until the first edge loads d.
    @(negedge clk);
    reset32 = 1'b0;
    d32     = 32'h12345678;
    #1;
    chk("rel32_before_edge", 128'(q32), 128'h0);
    @(posedge clk); #1;
    chk("rel32_after_edge", 128'(q32), 128'h12345678);

    // d changes between edges: q must hold.
    #2;
    d32 = 32'hFFFFFFFF;
    #1;
    chk("hold32_midcycle", 128'(q32), 128'h12345678);
    @(negedge clk); #1;
    chk("hold32_negedge", 128'(q32), 128'h12345678);
    @(posedge clk); #1;
    chk("load32_ffff", 128'(q32), 128'hFFFFFFFF);

    // Reset raised between edges takes effect without a clock edge.
    @(negedge clk); #1;
    t_raise = $time;
    reset32 = 1'b1;
    #1;
    chk("rst32_midcycle", 128'(q32), 128'h0);
    chk("rst32_no_edge_elapsed", 128'(($time - t_raise) < 4), 128'h1);

    // Release and check stored data is not restored.
    @(negedge clk);
    reset32 = 1'b0;
    d32     = 32'hAAAA5555;
    #1;
    chk("rel32_no_restore", 128'(q32), 128'h0);
    @(posedge clk); #1;
    chk("load32_aaaa", 128'(q32), 128'hAAAA5555);

    // Reset coinciding with a clock edge wins.
    @(negedge clk);
    d32 = 32'h0F0F0F0F;
    @(posedge clk);
    reset32 = 1'b1;
    #1;
    chk("rst32_vs_edge", 128'(q32), 128'h0);
    @(negedge clk);
    reset32 = 1'b0;

    // 108-bit streaming of four distinct random vectors.
    for (int i = 0; i < 4; i++) begin
      vec[i] = {$urandom, $urandom, $urandom, $urandom};
      vec[i][107:104] = 4'(i);
    end
    @(negedge clk);
    reset108 = 1'b0;
    prev     = '0;
    for (int i = 0; i < 4; i++) begin
      d108 = vec[i];
      #1;
      chk("w108_before_edge", 128'(q108), 128'(prev));
      @(posedge clk); #1;
      chk("w108_after_edge", 128'(q108), 128'(vec[i]));
      prev = vec[i];
    end

    // 8-bit with non-zero reset value.
    @(negedge clk);
    reset8 = 1'b0;
    d8     = 8'h3C;
    #1;
    chk("w8_before_edge", 128'(q8), 128'hA5);
    @(posedge clk); #1;
    chk("w8_after_edge", 128'(q8), 128'h3C);
    reset8 = 1'b1;
    #1;
    chk("w8_rst_again", 128'(q8), 128'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flopr.md
FLOPR -- requirements
Module: flopr

Interface
REQ-001 The module SHALL have one clock and one asynchronous, active-high reset, with ports named clk and reset.
REQ-002 The module SHALL declare parameter WIDTH, default 32, meaning the data width in bits; legal values are 1 or more, and pipeline use includes widths above 100 (e.g. 108).
REQ-003 The module SHALL declare parameter RESET_VALUE, default all-zeros of WIDTH bits, meaning the value loaded into q on reset.
REQ-004 The module SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port d, input, WIDTH bits: next-state data.
REQ-007 The module SHALL have port q, output, WIDTH bits: registered data.
REQ-008 The module SHALL have no other ports, so that named-port instantiation with clk/reset/d/q is complete.

Function
REQ-009 On each rising edge of clk with reset low, q SHALL take the value of d sampled at that edge, with exactly one cycle of latency.
REQ-010 Between rising clk edges, with reset low, q SHALL hold its value regardless of changes on d.
REQ-011 There SHALL be no combinational path from d to q.
REQ-012 All WIDTH bits SHALL be captured in the same edge, with no per-bit or partial update.
REQ-013 There SHALL be no enable or clear; every non-reset rising edge loads d.
REQ-014 The block SHALL contain exactly WIDTH storage bits, with no internal state beyond q.
REQ-015 The block SHALL be synthesizable as WIDTH D flip-flops with asynchronous set/clear, where RESET_VALUE bits select set or clear per bit.
REQ-016 The block SHALL have no simulation-only constructs such as $display or assertions in the datapath.

Reset
REQ-017 When reset goes high, q SHALL become RESET_VALUE immediately, without waiting for a clk edge.
REQ-018 While reset is high, q SHALL stay at RESET_VALUE, and rising clk edges SHALL be ignored.
REQ-019 If reset and a rising clk edge occur together, reset SHALL win and q SHALL equal RESET_VALUE.
REQ-020 After reset falls, q SHALL hold RESET_VALUE until the first rising clk edge with reset low, which loads d.
REQ-021 If reset is asserted mid-operation, the stored data SHALL be discarded, with no restore after release.
REQ-022 At time zero, before any reset, q SHALL be unknown; users MUST reset before relying on q.

Verification
REQ-023 Bench scenario: WIDTH=32. Assert reset, then drive d=32'hDEADBEEF and toggle clk -> q=32'h0 throughout reset.
REQ-024 Bench scenario: release reset, d=32'h12345678, one rising edge -> q=32'h12345678 after the edge; before the edge q=0.
REQ-025 Bench scenario: d changes to 32'hFFFFFFFF mid-cycle with no edge -> q remains 32'h12345678 until the next rising edge, then becomes 32'hFFFFFFFF.
REQ-026 Bench scenario: q=32'hFFFFFFFF, then raise reset between clock edges -> q=0 within the same timestep, with no clk edge needed.
REQ-027 Bench scenario: WIDTH=108, RESET_VALUE=0. Stream 4 distinct random vectors on consecutive edges -> q matches each d one cycle later, bit-exact across all 108 bits.
REQ-028 Bench scenario: WIDTH=8, RESET_VALUE=8'hA5. Assert reset -> q=8'hA5. Release reset, d=8'h3C, one edge -> q=8'h3C.
